// File: rtl/irq_service_master.sv
// irq_service_master: Avalon-MM initiator that reads/acks interrupt pending bits and emits them as events (optional IRQ_SVC_MASK_EN adds irq_mask)
module irq_service_master #(
   parameter logic [1:0] PENDING_ADDR = 2'd0,
   parameter logic [1:0] ACK_ADDR     = 2'd1,
   parameter int         TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
`ifdef IRQ_SVC_MASK_EN
   input  logic [31:0] irq_mask,
`endif
   output logic [1:0]  avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        evt_valid,
   output logic [31:0] evt_data,
   input  logic        evt_ready,
   output logic        busy,
   output logic        err_timeout,
   output logic [7:0]  spurious_cnt
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, ACK_REQ, EMIT} state_t;
   state_t      state, next;
   logic [7:0]  cnt;
   logic [31:0] cap, mask, cap_val;
   logic        rd_hit, waiting, tmo, abort;
`ifdef IRQ_SVC_MASK_EN
   assign mask = irq_mask;
`else
   assign mask = '1;
`endif
   assign cap_val = avm_readdata & mask;
   assign rd_hit  = avm_readdatavalid && ((state == RD_REQ && !avm_waitrequest) || state == RD_WAIT);
   assign waiting = state == RD_REQ || state == RD_WAIT || state == ACK_REQ;
   assign tmo     = cnt == 8'(TIMEOUT - 1);
   assign abort   = tmo && (((state == RD_REQ || state == ACK_REQ) && avm_waitrequest) ||
                            (state == RD_WAIT && !avm_readdatavalid));
   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end
   // next-state: progress on bus acceptance / data / handshake, abort on timeout
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = irq ? RD_REQ : IDLE;
         RD_REQ:  next = !avm_waitrequest ? (avm_readdatavalid ? (cap_val == '0 ? IDLE : ACK_REQ) : RD_WAIT)
                                          : (abort ? IDLE : RD_REQ);
         RD_WAIT: next = avm_readdatavalid ? (cap_val == '0 ? IDLE : ACK_REQ) : (abort ? IDLE : RD_WAIT);
         ACK_REQ: next = !avm_waitrequest ? EMIT : (abort ? IDLE : ACK_REQ);
         EMIT:    next = evt_ready ? IDLE : EMIT;
         default: next = IDLE;
      endcase
   end
   // timeout counter, capture register and status flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt          <= '0;
         cap          <= '0;
         err_timeout  <= 1'b0;
         spurious_cnt <= '0;
      end else begin
         cnt <= (next != state || !waiting) ? '0 : cnt + 8'd1;
         if (rd_hit) cap <= cap_val;
         if (abort) err_timeout <= 1'b1;
         if (rd_hit && cap_val == '0 && spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
      end
   end
   // bus and event outputs decoded from state
   always_comb begin
      avm_read       = state == RD_REQ;
      avm_write      = state == ACK_REQ;
      avm_address    = state == RD_REQ ? PENDING_ADDR : (state == ACK_REQ ? ACK_ADDR : 2'd0);
      avm_byteenable = waiting && state != RD_WAIT ? 4'hF : 4'h0;
      avm_writedata  = state == ACK_REQ ? cap : '0;
      evt_valid      = state == EMIT;
      evt_data       = state == EMIT ? cap : '0;
      busy           = state != IDLE;
   end
endmodule

// File: tb/tb_irq_service_master.sv
// tb_irq_service_master: randomized scoreboard bench with an Avalon slave model for irq_service_master
module tb_irq_service_master;
   logic        clk = 0, reset = 0, irq = 0;
   logic [1:0]  avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_writedata, avm_readdata, evt_data;
   logic        evt_valid, evt_ready, busy, err_timeout;
   logic [7:0]  spurious_cnt;
   int          vectors = 0, miscompares = 0;
   logic [31:0] exp_wr[$], exp_evt[$];
   int          model_spur = 0;
   int          ws = 0, dly = 1, stall = 0, rd_cnt = 0;
   logic        rd_pend = 0, withhold = 0, fixed_en = 1, rnd_ready = 0, ready_val = 1;
   logic [31:0] fixed_data = 0;
   logic        st_v = 0, ev_v = 0;
   logic [39:0] st_prev;
   logic [32:0] ev_prev;

   irq_service_master dut (
      .clk(clk), .reset(reset), .irq(irq),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
      .busy(busy), .err_timeout(err_timeout), .spurious_cnt(spurious_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // reference model: a returned pending word is either acked+emitted verbatim or counted as spurious
   task automatic give_data();
      logic [31:0] d;
      d = fixed_en ? fixed_data : (($urandom % 4 == 0) ? 32'h0 : $urandom);
      avm_readdata = d;
      avm_readdatavalid = 1;
      if (d != 0) begin
         exp_wr.push_back(d);
         exp_evt.push_back(d);
      end else if (model_spur < 255) model_spur++;
   endtask

   // Avalon slave model with configurable wait states and read latency
   initial begin
      avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0; evt_ready = 0;
      forever begin
         @(posedge clk); #2;
         avm_readdatavalid = 0;
         evt_ready = rnd_ready ? 1'($urandom % 2) : ready_val;
         if (!busy) rd_pend = 0;
         if (rd_pend) begin
            if (rd_cnt <= 1) begin give_data(); rd_pend = 0; end
            else rd_cnt--;
         end
         if (!(avm_read || avm_write)) begin
            avm_waitrequest = 0; stall = ws;
         end else if (stall > 0) begin
            avm_waitrequest = 1; stall--;
         end else begin
            avm_waitrequest = 0; stall = ws;
            if (avm_read && !withhold) begin
               if (dly == 0) give_data();
               else begin rd_pend = 1; rd_cnt = dly; end
            end
         end
      end
   end

   // monitor: pops scoreboard on write acceptance and event handshake, checks stall stability
   always @(negedge clk) begin
      if (!reset) begin
         st_v <= 0; ev_v <= 0;
      end else begin
         if (avm_read || avm_write) chk("rw_exclusive", avm_read & avm_write, 0);
         if (avm_write && !avm_waitrequest) begin
            if (exp_wr.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: got %0h expected none", avm_writedata);
            end else begin
               chk("ack_data", avm_writedata, exp_wr.pop_front());
               chk("ack_addr", {avm_address, avm_byteenable}, {2'd1, 4'hF});
            end
         end
         if (evt_valid && evt_ready) begin
            if (exp_evt.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_event: got %0h expected none", evt_data);
            end else chk("evt_data", evt_data, exp_evt.pop_front());
         end
         if (st_v) chk("stall_hold", {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}, st_prev);
         if (ev_v) chk("evt_hold", {evt_valid, evt_data}, ev_prev);
         st_v <= (avm_read || avm_write) && avm_waitrequest;
         st_prev <= {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};
         ev_v <= evt_valid && !evt_ready;
         ev_prev <= {evt_valid, evt_data};
      end
   end

   task automatic pulse();
      @(posedge clk); #1 irq = 1;
      @(posedge clk); #1 irq = 0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (busy && n < bound);
      chk("idle_wait", busy, 0);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus", {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata}, 0);
      chk("rst_evt", {evt_valid, evt_data, busy}, 0);
      chk("rst_flags", {err_timeout, spurious_cnt}, 0);
      reset = 1;
      // minimum latency, single pending bit
      ws = 0; dly = 1; fixed_data = 32'h10; ready_val = 1;
      @(posedge clk); #1 irq = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; if (n == 1) irq = 0; end while (!evt_valid && n < 20);
      chk("latency", n, 4);
      wait_idle(50);
      // three wait states on read and write
      ws = 3; fixed_data = 32'h55;
      pulse(); wait_idle(100);
      // backpressure with irq held high
      ws = 0; fixed_data = 32'h80; ready_val = 0;
      @(posedge clk); #1 irq = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!evt_valid && n < 50);
      chk("bp_valid", evt_valid, 1);
      repeat (10) @(posedge clk);
      #1 ready_val = 1;
      @(posedge clk); #1;
      chk("bp_gap_read", {busy, avm_read}, 0);
      @(posedge clk); #1;
      chk("bp_reread", avm_read, 1);
      irq = 0;
      wait_idle(50);
      // spurious interrupts saturate the counter
      fixed_data = 0;
      pulse(); wait_idle(50);
      chk("spur_one", spurious_cnt, 1);
      repeat (299) begin pulse(); wait_idle(50); end
      chk("spur_sat", spurious_cnt, 255);
      // randomized traffic
      fixed_en = 0; rnd_ready = 1;
      for (int i = 0; i < 40; i++) begin
         ws = $urandom % 4; dly = $urandom % 4;
         pulse(); wait_idle(300);
      end
      rnd_ready = 0; ready_val = 1; fixed_en = 1;
      chk("spur_model", spurious_cnt, model_spur);
      // read data withheld -> timeout
      ws = 0; dly = 1; fixed_data = 32'h3; withhold = 1;
      @(posedge clk); #1 irq = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; if (n == 1) irq = 0; end while (!err_timeout && n < 400);
      chk("tmo_cycles", n, 257);
      chk("tmo_idle", busy, 0);
      withhold = 0;
      pulse(); wait_idle(50);
      chk("tmo_sticky", err_timeout, 1);
      chk("wr_q_empty", exp_wr.size(), 0);
      chk("evt_q_empty", exp_evt.size(), 0);
      // reset during the acknowledge write
      ws = 5; fixed_data = 32'h1;
      pulse();
      n = 0;
      while (!avm_write && n < 50) begin @(posedge clk); #1; n++; end
      chk("in_ack", avm_write, 1);
      reset = 0;
      @(posedge clk); #1;
      chk("mid_rst_bus", {avm_write, avm_read, busy, evt_valid}, 0);
      chk("mid_rst_flags", {err_timeout, spurious_cnt}, 0);
      exp_wr.delete(); exp_evt.delete();
      ws = 0; reset = 1;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
